// File: rtl/hue_sequencer.sv
// hue_sequencer: walks the HSV hue wheel one sextant at a time and presents
// RGB duty sets to the PWM stage over a valid/ready handshake. A step only
// advances once the previously presented set has been taken, so no step is
// ever dropped or merged.
module hue_sequencer #(
  parameter int PWM_INTERVAL  = 1200,
  parameter int STEP_CYCLES   = 20000,
  parameter int SEXTANT_STEPS = 100,
  localparam int DW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          duty_ready,
  output logic          duty_valid,
  output logic [DW-1:0] r_duty,
  output logic [DW-1:0] g_duty,
  output logic [DW-1:0] b_duty,
  output logic [2:0]    sextant,
  output logic          wrap
);

  localparam int DUTY_STEP = PWM_INTERVAL / SEXTANT_STEPS;
  localparam int TW        = $clog2(STEP_CYCLES + 1);
  localparam int SW        = $clog2(SEXTANT_STEPS + 1);

  // A fractional duty increment would break continuity at sextant edges.
  if ((PWM_INTERVAL % SEXTANT_STEPS) != 0) begin : g_bad_params
    $error("hue_sequencer: PWM_INTERVAL must be a multiple of SEXTANT_STEPS");
  end

  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] step_q, step_d;
  logic [2:0]    sextant_q, sextant_d;
  logic          wrap_q, wrap_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic          tick, advance;

  // Maps a (sextant, step) position on the hue wheel to an {R,G,B} duty set.
  function automatic logic [3*DW-1:0] duty_set(input logic [2:0] sx,
                                               input logic [SW-1:0] st);
    logic [DW-1:0] ramp, rise, fall, hi, lo;
    ramp = DW'(st) * DW'(DUTY_STEP);
    hi   = DW'(PWM_INTERVAL);
    lo   = '0;
    rise = ramp;
    fall = hi - ramp;
    case (sx)
      3'd0:    duty_set = {hi,   rise, lo  };
      3'd1:    duty_set = {fall, hi,   lo  };
      3'd2:    duty_set = {lo,   hi,   rise};
      3'd3:    duty_set = {lo,   fall, hi  };
      3'd4:    duty_set = {rise, lo,   hi  };
      3'd5:    duty_set = {hi,   lo,   fall};
      default: duty_set = {hi,   lo,   lo  };
    endcase
  endfunction

  // Step timer, hue position, handshake and next duty set.
  always_comb begin
    tick      = run && (timer_q == TW'(STEP_CYCLES - 1));
    advance   = tick && (!valid_q || duty_ready);
    timer_d   = timer_q;
    step_d    = step_q;
    sextant_d = sextant_q;
    wrap_d    = 1'b0;
    valid_d   = valid_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    if (advance) begin
      timer_d = '0;
      if (step_q == SW'(SEXTANT_STEPS - 1)) begin
        step_d = '0;
        if (sextant_q == 3'd5) begin
          sextant_d = 3'd0;
          wrap_d    = 1'b1;
        end else begin
          sextant_d = sextant_q + 3'd1;
        end
      end else begin
        step_d = step_q + SW'(1);
      end
      {r_d, g_d, b_d} = duty_set(sextant_d, step_d);
      valid_d         = 1'b1;
    end else begin
      // A tick that cannot advance parks the timer at its last count so
      // the advance is retried every cycle until the consumer is ready.
      if (run && !tick) timer_d = timer_q + TW'(1);
      if (valid_q && duty_ready) valid_d = 1'b0;
    end
  end

  // State registers; reset presents the pure-red set immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q   <= '0;
      step_q    <= '0;
      sextant_q <= 3'd0;
      wrap_q    <= 1'b0;
      valid_q   <= 1'b1;
      r_q       <= DW'(PWM_INTERVAL);
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      timer_q   <= timer_d;
      step_q    <= step_d;
      sextant_q <= sextant_d;
      wrap_q    <= wrap_d;
      valid_q   <= valid_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign duty_valid = valid_q;
  assign r_duty     = r_q;
  assign g_duty     = g_q;
  assign b_duty     = b_q;
  assign sextant    = sextant_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Directed bench for hue_sequencer with small parameters
// (PWM_INTERVAL=16, STEP_CYCLES=4, SEXTANT_STEPS=4, DUTY_STEP=4).
module tb_hue_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       duty_ready = 1'b0;
  logic       duty_valid;
  logic [4:0] r_duty, g_duty, b_duty;
  logic [2:0] sextant;
  logic       wrap;

  int tests = 0;
  int fails = 0;

  hue_sequencer #(
    .PWM_INTERVAL (16),
    .STEP_CYCLES  (4),
    .SEXTANT_STEPS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .duty_ready(duty_ready),
    .duty_valid(duty_valid),
    .r_duty    (r_duty),
    .g_duty    (g_duty),
    .b_duty    (b_duty),
    .sextant   (sextant),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic check_set(input string tag, input int r, input int g, input int b, input int sx);
    check({tag, "_r"}, 32'(r_duty), 32'(r));
    check({tag, "_g"}, 32'(g_duty), 32'(g));
    check({tag, "_b"}, 32'(b_duty), 32'(b));
    check({tag, "_sx"}, 32'(sextant), 32'(sx));
  endtask

  // Hand-computed checkpoints: edge after release -> sextant, r, g, b.
  int ck_e [14] = '{4, 8, 12, 16, 20, 32, 36, 48, 52, 64, 68, 80, 84, 96};
  int ck_sx[14] = '{0, 0, 0,  1,  1,  2,  2,  3,  3,  4,  4,  5,  5,  0};
  int ck_r [14] = '{16,16,16, 16, 12, 0,  0,  0,  0,  0,  4,  16, 16, 16};
  int ck_g [14] = '{4, 8, 12, 16, 16, 16, 16, 16, 12, 0,  0,  0,  0,  0};
  int ck_b [14] = '{0, 0, 0,  0,  0,  0,  4,  16, 16, 16, 16, 16, 12, 0};

  initial begin
    int wraps;
    int ci;
    logic found;

    // Reset state, held across edges.
    edge1();
    edge1();
    check_set("rst", 16, 0, 0, 0);
    check("rst_valid", 32'(duty_valid), 1);
    check("rst_wrap", 32'(wrap), 0);

    // Release with run=1, ready=0: timer parks at 3, nothing advances.
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 10; i++) edge1();
    check("stall_timer", 32'(dut.timer_q), 3);
    check_set("stall", 16, 0, 0, 0);
    check("stall_valid", 32'(duty_valid), 1);

    // One-cycle ready: exactly one step, new set still presented.
    duty_ready = 1'b1;
    edge1();
    duty_ready = 1'b0;
    check_set("bp_adv", 16, 4, 0, 0);
    check("bp_adv_valid", 32'(duty_valid), 1);
    for (int i = 0; i < 10; i++) edge1();
    check_set("bp_hold", 16, 4, 0, 0);
    check("bp_hold_valid", 32'(duty_valid), 1);
    check("bp_hold_timer", 32'(dut.timer_q), 3);

    // Free-running walk of the whole wheel with ready=1.
    @(negedge clk);
    rst = 1'b0;
    duty_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    wraps = 0;
    ci = 0;
    for (int e = 1; e <= 97; e++) begin
      edge1();
      if (wrap === 1'b1) wraps++;
      if (e == 1) check("walk_valid_drop", 32'(duty_valid), 0);
      if (e == 4) check("walk_valid_load", 32'(duty_valid), 1);
      if (e == 95) check("walk_nowrap_95", 32'(wrap), 0);
      if (e == 96) check("walk_wrap_96", 32'(wrap), 1);
      if (e == 97) check("walk_wrap_97", 32'(wrap), 0);
      if (ci < 14 && e == ck_e[ci]) begin
        check_set($sformatf("walk_e%0d", e), ck_r[ci], ck_g[ci], ck_b[ci], ck_sx[ci]);
        ci++;
      end
    end
    check("wrap_count", 32'(wraps), 1);

    // Freeze with timer=2: seven cycles of run=0, then tick two cycles later.
    edge1();
    check("frz_timer_pre", 32'(dut.timer_q), 2);
    run = 1'b0;
    for (int i = 0; i < 7; i++) edge1();
    check("frz_timer", 32'(dut.timer_q), 2);
    check_set("frz", 16, 0, 0, 0);
    run = 1'b1;
    edge1();
    check_set("resume1", 16, 0, 0, 0);
    edge1();
    check_set("resume2", 16, 4, 0, 0);

    // Run into sextant 3, then pulse reset between clock edges.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      edge1();
      if (sextant === 3'd3) found = 1'b1;
    end
    check("reach_sx3", 32'(found), 1);
    edge1();
    edge1();
    #2;
    rst = 1'b0;
    #1;
    check_set("async_rst", 16, 0, 0, 0);
    check("async_rst_valid", 32'(duty_valid), 1);
    check("async_rst_wrap", 32'(wrap), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) edge1();
    check_set("post_rst", 16, 4, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
